// File: rtl/ones_counter_driver.sv
// ones_counter_driver: queues operands and sequences an attached ones counter, presenting each count downstream
// Ports:
//   clk, reset           clock and asynchronous active-high reset
//   in_valid/in_data     operand offer from upstream, accepted while in_ready
//   cnt_A, cnt_s         operand and start request to the ones counter
//   cnt_done, cnt_result done flag and result from the ones counter
//   out_valid/out_data   captured ones count, consumed while out_ready
//   q_count              number of queued operands
module ones_counter_driver #(
  parameter int N = 8,
  parameter int DEPTH = 4,
  localparam int W = $clog2(N + 1),
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  output logic [N-1:0]  cnt_A,
  output logic          cnt_s,
  input  logic          cnt_done,
  input  logic [W-1:0]  cnt_result,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  input  logic          out_ready,
  output logic [CW-1:0] q_count
);
  typedef enum logic [2:0] {IDLE, SETUP, BUSY, RELEASE, PRESENT} state_t;
  state_t r_state;
  logic [N-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  assign in_ready = r_count != CW'(DEPTH);
  assign q_count = r_count;
  assign w_push = in_valid & in_ready;
  // the head is only consumed once the counter has finished with it, keeping cnt_A stable
  assign w_pop = (r_state == BUSY) & cnt_done;
  assign cnt_A = (r_count != '0) ? r_mem[r_rd] : '0;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= in_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop) r_rd <= r_rd + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      cnt_s <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      case (r_state)
        IDLE: if (r_count != '0) r_state <= SETUP;
        SETUP: begin
          r_state <= BUSY;
          cnt_s <= 1'b1;
        end
        BUSY: if (cnt_done) begin
          r_state <= RELEASE;
          cnt_s <= 1'b0;
          out_data <= cnt_result;
        end
        RELEASE: if (!cnt_done) begin
          r_state <= PRESENT;
          out_valid <= 1'b1;
        end
        PRESENT: if (out_ready) begin
          r_state <= IDLE;
          out_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ones_counter_driver.sv
// tb_ones_counter_driver: scoreboard bench for ones_counter_driver with a behavioral ones counter attached
module tb_ones_counter_driver;
  localparam int N = 8, DEPTH = 4, W = 4, CW = 3;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [N-1:0] in_data = '0;
  logic in_ready, cnt_s, cnt_done, out_valid;
  logic [N-1:0] cnt_A;
  logic [W-1:0] cnt_result, out_data;
  logic [CW-1:0] q_count;
  int n_tests = 0, n_fail = 0, n_ov = 0, n_starts = 0, hold_cfg = 0;
  logic [W-1:0] sb[$];
  logic [N-1:0] opq[$];
  ones_counter_driver #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cnt_A(cnt_A), .cnt_s(cnt_s), .cnt_done(cnt_done), .cnt_result(cnt_result),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .q_count(q_count)
  );
  always #5 clk = ~clk;
  int c_st, c_hold;
  logic [N-1:0] c_a;
  logic [W-1:0] c_res;
  always @(posedge clk or posedge reset)
    if (reset) begin
      c_st <= 0;
      c_a <= '0;
      c_res <= '0;
      c_hold <= 0;
    end else begin
      case (c_st)
        0: if (cnt_s) c_st <= 1;
           else begin
             c_a <= cnt_A;
             c_res <= '0;
             c_hold <= hold_cfg;
           end
        1: if (c_a == '0) c_st <= 2;
           else begin
             c_res <= c_res + W'(c_a[0]);
             c_a <= c_a >> 1;
           end
        default: if (!cnt_s) begin
          if (c_hold > 0) c_hold <= c_hold - 1;
          else c_st <= 0;
        end
      endcase
    end
  assign cnt_done = (c_st == 2);
  assign cnt_result = c_res;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  logic prev_s = 0;
  logic [CW-1:0] prev_q = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_s = 0;
      prev_q = '0;
    end else begin
      if (cnt_s && opq.size() != 0) chk("cnt_A_stable", cnt_A, opq[0]);
      if (cnt_s && !prev_s) begin
        n_starts++;
        chk("setup_queue_nonempty", prev_q != '0, 1);
      end
      if (out_valid) begin
        n_ov++;
        if (sb.size() == 0) chk("unexpected_output_sb_size", sb.size(), 1);
        else if (out_ready) begin
          chk("out_data", out_data, sb.pop_front());
          void'(opq.pop_front());
        end else chk("out_data_hold", out_data, sb[0]);
      end
      prev_s = cnt_s;
      prev_q = q_count;
    end
  end
  task automatic push(input logic [N-1:0] d, input logic acc);
    in_valid = 1;
    in_data = d;
    @(negedge clk);
    chk("in_ready", in_ready, acc);
    @(posedge clk); #1;
    if (acc) begin
      sb.push_back(W'($countones(d)));
      opq.push_back(d);
    end
  endtask
  task automatic wait_done();
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && q_count == '0 && !out_valid) break;
    end
    chk("drain_sb", sb.size(), 0);
    chk("drain_q_count", q_count, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    int rel;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_q_count", q_count, 0);
    chk("rst_cnt_s", cnt_s, 0);
    chk("rst_cnt_A", cnt_A, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    reset = 0;
    @(posedge clk); #1;
    out_ready = 1;
    n_ov = 0;
    n_starts = 0;
    push(8'b10110110, 1);
    in_valid = 0;
    chk("first_push_q_count", q_count, 1);
    wait_done();
    chk("single_ov_cycles", n_ov, 1);
    chk("single_starts", n_starts, 1);
    n_ov = 0;
    n_starts = 0;
    push(8'h00, 1);
    push(8'hFF, 1);
    in_valid = 0;
    wait_done();
    chk("pair_starts", n_starts, 2);
    chk("pair_ov_cycles", n_ov, 2);
    out_ready = 0;
    push(8'h01, 1);
    push(8'h03, 1);
    push(8'h07, 1);
    push(8'h0F, 1);
    push(8'hFF, 0);
    in_valid = 0;
    repeat (30) @(posedge clk);
    #1;
    chk("held_out_valid", out_valid, 1);
    chk("held_q_count", q_count, 3);
    out_ready = 1;
    wait_done();
    hold_cfg = 3;
    push(8'h0F, 1);
    in_valid = 0;
    rel = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!cnt_s && cnt_done) begin
        rel++;
        chk("ov_during_release", out_valid, 0);
      end
      if (out_valid) break;
    end
    chk("release_hold_cycles", rel >= 4, 1);
    @(posedge clk); #1;
    wait_done();
    hold_cfg = 0;
    push(8'h80, 1);
    push(8'h81, 1);
    push(8'h82, 1);
    in_valid = 0;
    chk("busy_q_count", q_count, 3);
    chk("busy_cnt_s", cnt_s, 1);
    #2 reset = 1;
    #1;
    chk("async_cnt_s", cnt_s, 0);
    chk("async_q_count", q_count, 0);
    chk("async_out_valid", out_valid, 0);
    chk("async_cnt_A", cnt_A, 0);
    sb.delete();
    opq.delete();
    @(negedge clk);
    reset = 0;
    in_valid = 1;
    in_data = 8'hA5;
    @(posedge clk); #1;
    in_valid = 0;
    chk("post_reset_push", q_count, 1);
    sb.push_back(W'(4));
    opq.push_back(8'hA5);
    wait_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ones_counter_driver.md
ONES_COUNTER_DRIVER -- requirements
Module: ones_counter_driver

Interface
REQ-001 Parameter N, default 8: operand width in bits; SHALL match N of the attached ones counter.
REQ-002 Parameter DEPTH, default 4: operand queue depth, power of two, at least 2.
REQ-003 Derived width W = $clog2(N+1): result width.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 reset  input  1  asynchronous, active-high; asserting it SHALL immediately force all state to reset values.
REQ-006 in_valid  input  1  upstream offers an operand.
REQ-007 in_data  input  N  operand to be counted.
REQ-008 in_ready  output  1  queue can accept an operand.
REQ-009 cnt_A  output  N  operand driven to the counter's A input.
REQ-010 cnt_s  output  1  start request driven to the counter's s input.
REQ-011 cnt_done  input  1  done from the counter.
REQ-012 cnt_result  input  W  result register of the counter.
REQ-013 out_valid  output  1  result available downstream.
REQ-014 out_data  output  W  captured ones count.
REQ-015 out_ready  input  1  downstream accepts a result.
REQ-016 q_count  output  $clog2(DEPTH+1)  number of queued operands.

Function
REQ-017 The block SHALL hold a FIFO of DEPTH operands; push on in_valid & in_ready; in_ready = (q_count != DEPTH).
REQ-018 cnt_A SHALL equal the FIFO head when q_count != 0; otherwise it SHALL be 0.
REQ-019 The FSM SHALL have five states: IDLE, SETUP, BUSY, RELEASE, PRESENT.
REQ-020 IDLE: cnt_s=0; if q_count != 0, go to SETUP; otherwise stay in IDLE.
REQ-021 SETUP: cnt_s=0 for exactly one cycle so the counter loads cnt_A; then go to BUSY.
REQ-022 BUSY: cnt_s=1; on cnt_done=1, capture cnt_result into out_data, pop the FIFO head, and go to RELEASE.
REQ-023 RELEASE: cnt_s=0; wait for cnt_done=0, then go to PRESENT.
REQ-024 PRESENT: out_valid=1; on out_ready=1, go to IDLE; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 out_valid SHALL be 1 only in PRESENT; cnt_s SHALL be 1 only in BUSY.
REQ-026 The FIFO head SHALL NOT change from SETUP entry until the pop in BUSY, so cnt_A stays stable throughout the counter operation.
REQ-027 A push and a pop in the same cycle SHALL leave q_count unchanged and preserve FIFO order.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH.
REQ-029 Operand 0 SHALL complete normally with out_data=0.
REQ-030 A push while in_ready=0 SHALL be ignored, with no state change.
REQ-031 Latency from IDLE with a non-empty queue to out_valid SHALL be 2 + counter busy cycles + release wait cycles.

Reset
REQ-032 On reset, the block SHALL set state=IDLE, FIFO empty, q_count=0, in_ready=1, cnt_s=0, cnt_A=0, out_valid=0 and out_data=0.
REQ-033 Reset asserted mid-operation SHALL abandon the operand in flight and all queued operands, with no output produced.
REQ-034 The first FIFO push after reset deasserts SHALL be accepted on the first clk edge.

Verification
REQ-035 Push 8'b10110110 with out_ready=1 and the counter attached -> cnt_s low one cycle, then high until done; out_valid with out_data=5 for one cycle; q_count returns to 0.
REQ-036 Push 8'h00, then 8'hFF -> results 0 then 8 appear in order; cnt_s drops between the two operations and SETUP precedes each.
REQ-037 Push 5 operands back-to-back with out_ready=0 -> in_ready=0 once q_count=4 and the fifth push is ignored; result 1 is held stable on out_data; raising out_ready drains the remaining results in push order.
REQ-038 Push 8'h0F with the counter forced to hold cnt_done=1 through RELEASE for 3 extra cycles -> out_valid stays 0 until cnt_done falls; out_data=4 after that.
REQ-039 Assert reset asynchronously while in BUSY with q_count=3 -> cnt_s=0, q_count=0 and out_valid=0 immediately, with no clock edge required; the next push completes correctly.
